// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Optional stall-cycle counter is enabled by HAZARD_SCOREBOARD_PERF_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } drain_state_t;

    localparam int DEF_SEL_WIDTH = 4;
    localparam int DEF_CNT_WIDTH = 2;
    localparam int DEF_CNT_MAX   = (1 << DEF_CNT_WIDTH) - 1;

    // Largest value a pending counter of the given width may hold.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/drain signal bundle for hazard_scoreboard.
// o_stall_cycles exists only when HAZARD_SCOREBOARD_PERF_EN is defined.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS  = 16,
    parameter int SEL_WIDTH = 4
);
    logic                 i_decoder_valid;
    logic [SEL_WIDTH-1:0] i_decoder_rs1;
    logic                 i_decoder_rs1_en;
    logic [SEL_WIDTH-1:0] i_decoder_rs2;
    logic                 i_decoder_rs2_en;
    logic [SEL_WIDTH-1:0] i_decoder_ws;
    logic                 i_decoder_we;
    logic [SEL_WIDTH-1:0] i_writeback_ws;
    logic                 i_writeback_we;
    logic                 i_drain_req;
    logic                 o_stall;
    logic                 o_issue;
    logic [NUM_REGS-1:0]  o_busy_mask;
    logic                 o_drained;
    logic                 o_underflow;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]          o_stall_cycles;
`endif

    modport master (
        output i_decoder_valid, i_decoder_rs1, i_decoder_rs1_en,
               i_decoder_rs2, i_decoder_rs2_en, i_decoder_ws, i_decoder_we,
               i_writeback_ws, i_writeback_we, i_drain_req,
        input  o_stall, o_issue, o_busy_mask, o_drained, o_underflow
`ifdef HAZARD_SCOREBOARD_PERF_EN
        , input o_stall_cycles
`endif
    );

    modport slave (
        input  i_decoder_valid, i_decoder_rs1, i_decoder_rs1_en,
               i_decoder_rs2, i_decoder_rs2_en, i_decoder_ws, i_decoder_we,
               i_writeback_ws, i_writeback_we, i_drain_req,
        output o_stall, o_issue, o_busy_mask, o_drained, o_underflow
`ifdef HAZARD_SCOREBOARD_PERF_EN
        , output o_stall_cycles
`endif
    );

endinterface

// File: rtl/pending_counter.sv
// One per-register in-flight write counter; simultaneous inc and dec cancel.
module pending_counter
    import hazard_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic full,
    output logic underflow
);
    localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && !dec) begin
            count_next = count_reg + 1'b1;
        end else if (dec && !inc && count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign busy      = (count_reg != '0);
    assign full      = (count_reg == MAX_VAL);
    // A retire with nothing outstanding is clamped at zero and flagged.
    assign underflow = dec && !inc && (count_reg == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/saturation stall scoreboard with a drain FSM for halt entry.
// Define HAZARD_SCOREBOARD_PERF_EN to add the o_stall_cycles performance counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_reset,
    hazard_scoreboard_if.slave bus
);
    logic [NUM_REGS-1:0] rs1_hit;
    logic [NUM_REGS-1:0] rs2_hit;
    logic [NUM_REGS-1:0] ws_hit;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] uflow_vec;

    logic haz1;
    logic haz2;
    logic sat;
    logic stall;
    logic issue;
    logic in_run;
    logic drained;
    logic underflow_reg;

    drain_state_t state_reg;
    drain_state_t state_next;

    // Selectors at or above NUM_REGS match no slot, so they never hit, inc or dec.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign rs1_hit[gi] = bus.i_decoder_rs1_en && (bus.i_decoder_rs1 == SEL_WIDTH'(gi));
            assign rs2_hit[gi] = bus.i_decoder_rs2_en && (bus.i_decoder_rs2 == SEL_WIDTH'(gi));
            assign ws_hit[gi]  = bus.i_decoder_we     && (bus.i_decoder_ws  == SEL_WIDTH'(gi));
            assign wb_hit[gi]  = bus.i_writeback_we   && (bus.i_writeback_ws == SEL_WIDTH'(gi));
            assign inc_vec[gi] = issue && ws_hit[gi];
            assign dec_vec[gi] = wb_hit[gi];

            pending_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .inc       (inc_vec[gi]),
                .dec       (dec_vec[gi]),
                .busy      (busy_vec[gi]),
                .full      (full_vec[gi]),
                .underflow (uflow_vec[gi])
            );
        end
    endgenerate

    // Hazards look only at registered counts: a same-cycle retire does not bypass.
    assign haz1  = |(rs1_hit & busy_vec);
    assign haz2  = |(rs2_hit & busy_vec);
    assign sat   = |(ws_hit & full_vec);
    assign stall = bus.i_decoder_valid && (!in_run || haz1 || haz2 || sat);
    assign issue = bus.i_decoder_valid && !stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Dropping the request aborts a drain even if the mask cleared the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (bus.i_drain_req) state_next = DRAIN;
            DRAIN: begin
                if (!bus.i_drain_req) begin
                    state_next = RUN;
                end else if (busy_vec == '0) begin
                    state_next = DRAINED;
                end
            end
            DRAINED: if (!bus.i_drain_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        in_run  = (state_reg == RUN);
        drained = (state_reg == DRAINED);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            underflow_reg <= 1'b0;
        end else if (|uflow_vec) begin
            underflow_reg <= 1'b1;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cycles_reg <= '0;
        end else if (stall) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign bus.o_stall_cycles = stall_cycles_reg;
`endif

    assign bus.o_stall     = stall;
    assign bus.o_issue     = issue;
    assign bus.o_busy_mask = busy_vec;
    assign bus.o_drained   = drained;
    assign bus.o_underflow = underflow_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; covers hazards, saturation, underflow, drain and async reset.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    hazard_scoreboard_if #(.NUM_REGS(16), .SEL_WIDTH(4)) bus ();

    hazard_scoreboard #(
        .NUM_REGS  (16),
        .SEL_WIDTH (4),
        .CNT_WIDTH (2)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v,
                         input logic [3:0] rs1, input logic r1e,
                         input logic [3:0] rs2, input logic r2e,
                         input logic [3:0] ws,  input logic we,
                         input logic [3:0] wbws, input logic wbwe);
        bus.i_decoder_valid  = v;
        bus.i_decoder_rs1    = rs1;
        bus.i_decoder_rs1_en = r1e;
        bus.i_decoder_rs2    = rs2;
        bus.i_decoder_rs2_en = r2e;
        bus.i_decoder_ws     = ws;
        bus.i_decoder_we     = we;
        bus.i_writeback_ws   = wbws;
        bus.i_writeback_we   = wbwe;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    // Issue a write to ws (no reads, no retire) and expect it to go.
    task automatic issue_write(input string tag, input logic [3:0] ws);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ws, 1'b1, 4'd0, 1'b0);
        check_eq(tag, 32'(bus.o_issue), 32'd1);
        tick();
    endtask

    task automatic retire(input logic [3:0] ws);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, ws, 1'b1);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_drain_req = 1'b0;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check_eq("reset_busy",      32'(bus.o_busy_mask), 32'h0);
        check_eq("reset_drained",   32'(bus.o_drained),   32'd0);
        check_eq("reset_underflow", 32'(bus.o_underflow), 32'd0);
        check_eq("reset_stall",     32'(bus.o_stall),     32'd0);

        // RAW on rs1, no bypass on the retiring cycle.
        issue_write("raw_issue_w3", 4'd3);
        idle();
        check_eq("raw_busy3", 32'(bus.o_busy_mask), 32'h0008);
        drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("raw_stall_a", 32'(bus.o_stall), 32'd1);
        tick();
        check_eq("raw_stall_b", 32'(bus.o_stall), 32'd1);
        drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1);
        check_eq("raw_nobypass_stall", 32'(bus.o_stall), 32'd1);
        check_eq("raw_nobypass_issue", 32'(bus.o_issue), 32'd0);
        tick();
        drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("raw_after_stall", 32'(bus.o_stall), 32'd0);
        check_eq("raw_after_issue", 32'(bus.o_issue), 32'd1);
        tick();
        idle();
        check_eq("raw_busy_clear", 32'(bus.o_busy_mask), 32'h0);

        // RAW on rs2, and a disabled rs2 read does not stall.
        issue_write("rs2_issue_w4", 4'd4);
        drive(1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("rs2_stall", 32'(bus.o_stall), 32'd1);
        drive(1'b1, 4'd0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("rs2_disabled", 32'(bus.o_stall), 32'd0);
        retire(4'd4);

        // Saturation on ws=5.
        for (int i = 0; i < 3; i++) issue_write("sat_issue_w5", 4'd5);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0);
        check_eq("sat_stall", 32'(bus.o_stall), 32'd1);
        check_eq("sat_busy5", 32'(bus.o_busy_mask), 32'h0020);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1);
        check_eq("sat_retire_cycle_stall", 32'(bus.o_stall), 32'd1);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0);
        check_eq("sat_fourth_issue", 32'(bus.o_issue), 32'd1);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0);
        check_eq("sat_full_again", 32'(bus.o_stall), 32'd1);
        for (int i = 0; i < 3; i++) retire(4'd5);
        idle();
        check_eq("sat_busy_clear", 32'(bus.o_busy_mask), 32'h0);

        // Simultaneous inc and dec on ws=7 leaves the count at 1.
        issue_write("incdec_first_w7", 4'd7);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1);
        check_eq("incdec_issue", 32'(bus.o_issue), 32'd1);
        tick();
        idle();
        check_eq("incdec_busy7", 32'(bus.o_busy_mask), 32'h0080);
        retire(4'd7);
        idle();
        check_eq("incdec_busy_clear", 32'(bus.o_busy_mask), 32'h0);
        check_eq("incdec_no_underflow", 32'(bus.o_underflow), 32'd0);

        // Underflow on ws=9 is sticky.
        retire(4'd9);
        idle();
        check_eq("uflow_set", 32'(bus.o_underflow), 32'd1);
        check_eq("uflow_busy", 32'(bus.o_busy_mask), 32'h0);
        repeat (3) tick();
        check_eq("uflow_sticky", 32'(bus.o_underflow), 32'd1);

        // Drain with two writes pending.
        issue_write("drain_w1", 4'd1);
        issue_write("drain_w2", 4'd2);
        bus.i_drain_req = 1'b1;
        idle();
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("drain_stall", 32'(bus.o_stall), 32'd1);
        check_eq("drain_not_done", 32'(bus.o_drained), 32'd0);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("drain_mask_clear", 32'(bus.o_busy_mask), 32'h0);
        check_eq("drain_mask_clear_drained", 32'(bus.o_drained), 32'd0);
        tick();
        check_eq("drained_set", 32'(bus.o_drained), 32'd1);
        check_eq("drained_stall", 32'(bus.o_stall), 32'd1);
        bus.i_drain_req = 1'b0;
        #1;
        check_eq("drained_release_stall", 32'(bus.o_stall), 32'd1);
        tick();
        check_eq("resume_drained", 32'(bus.o_drained), 32'd0);
        check_eq("resume_issue", 32'(bus.o_issue), 32'd1);

        // Abort: dropping the request in DRAIN returns to RUN.
        issue_write("abort_w8", 4'd8);
        bus.i_drain_req = 1'b1;
        idle();
        tick();
        bus.i_drain_req = 1'b0;
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("abort_issue", 32'(bus.o_issue), 32'd1);
        check_eq("abort_busy8", 32'(bus.o_busy_mask), 32'h0100);
        retire(4'd8);

        // Async reset during DRAIN with a write pending.
        issue_write("areset_w6", 4'd6);
        bus.i_drain_req = 1'b1;
        idle();
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        check_eq("areset_pre_stall", 32'(bus.o_stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("areset_busy",      32'(bus.o_busy_mask), 32'h0);
        check_eq("areset_drained",   32'(bus.o_drained),   32'd0);
        check_eq("areset_stall",     32'(bus.o_stall),     32'd0);
        check_eq("areset_underflow", 32'(bus.o_underflow), 32'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check_eq("areset_stall_cycles", bus.o_stall_cycles, 32'd0);
`endif
        #1;
        rst = 1'b0;
        bus.i_drain_req = 1'b0;
        idle();
        tick();

`ifdef HAZARD_SCOREBOARD_PERF_EN
        // Three hazard-stalled cycles on rs1=10.
        issue_write("perf_w10", 4'd10);
        drive(1'b1, 4'd10, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        repeat (3) tick();
        idle();
        check_eq("perf_stall_cycles", bus.o_stall_cycles, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
